// File: rtl/z80_cycle_gen.sv
// Z80 bus cycle initiator: runs one memory or I/O read/write cycle with
// T-state timing, stepping one half-T-state per tick.
module z80_cycle_gen #(
  parameter int IO_WAITS = 1
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        tick,
  input  logic        req,
  input  logic        req_io,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        wait_n,
  input  logic [7:0]  d_in,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        mreq_n,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        busy,
  output logic [7:0]  rdata,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE, S_T1H, S_T1L, S_T2H, S_T2L, S_TWH, S_TWL, S_T3H, S_T3L
  } state_t;

  localparam logic [1:0] FORCED_INIT = 2'(IO_WAITS);

  state_t      state_q, state_d;
  logic [1:0]  forced_q, forced_d;   // forced I/O wait pairs still to run
  logic        io_q, io_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        done_q, done_d;

  logic accept;
  logic in_t1l_t3h, in_t2h_t3h, in_t2l_t3h;

  assign accept = tick && (state_q == S_IDLE) && req;

  // State and datapath registers; reset drops strobes at once via state_q.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      forced_q <= 2'd0;
      io_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      forced_q <= forced_d;
      io_q     <= io_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
    end
  end

  // Next-state: fixed T1/T2 sequence, forced I/O waits, then wait_n sampling.
  always_comb begin
    state_d  = state_q;
    forced_d = forced_q;
    if (tick) begin
      case (state_q)
        S_IDLE: if (req) state_d = S_T1H;
        S_T1H:  state_d = S_T1L;
        S_T1L:  state_d = S_T2H;
        S_T2H:  state_d = S_T2L;
        S_T2L: begin
          if (io_q && (IO_WAITS != 0)) begin
            state_d  = S_TWH;
            forced_d = FORCED_INIT;
          end else begin
            state_d = wait_n ? S_T3H : S_TWH;
          end
        end
        S_TWH:  state_d = S_TWL;
        S_TWL: begin
          // Only the exit of the last forced wait (or any extra wait) samples wait_n.
          if (forced_q > 2'd1) begin
            state_d  = S_TWH;
            forced_d = forced_q - 2'd1;
          end else begin
            forced_d = 2'd0;
            state_d  = wait_n ? S_T3H : S_TWH;
          end
        end
        S_T3H:  state_d = S_T3L;
        S_T3L:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Request latching, read capture at T3H exit and the end-of-cycle pulse.
  always_comb begin
    io_d    = io_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    if (accept) begin
      io_d    = req_io;
      wr_d    = req_wr;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end
    if (tick && (state_q == S_T3H) && !wr_q) rdata_d = d_in;
    if (tick && (state_q == S_T3L)) done_d = 1'b1;
  end

  // Output decode: strobe windows are derived from the current state only.
  always_comb begin
    in_t2l_t3h = (state_q == S_T2L) || (state_q == S_TWH) ||
                 (state_q == S_TWL) || (state_q == S_T3H);
    in_t2h_t3h = in_t2l_t3h || (state_q == S_T2H);
    in_t1l_t3h = in_t2h_t3h || (state_q == S_T1L);
    mreq_n = !(!io_q && in_t1l_t3h);
    iorq_n = !( io_q && in_t2h_t3h);
    rd_n   = !(!wr_q && (io_q ? in_t2h_t3h : in_t1l_t3h));
    wr_n   = !( wr_q && (io_q ? in_t2h_t3h : in_t2l_t3h));
    d_oe   = wr_q && (state_q != S_IDLE) && (state_q != S_T1H);
    busy   = (state_q != S_IDLE);
    a      = addr_q;
    d_out  = wdata_q;
    rdata  = rdata_q;
    done   = done_q;
  end

endmodule

// File: tb/tb_z80_cycle_gen.sv
// Bench for z80_cycle_gen: directed table plus randomized cycles checked
// against a phase-list model of the bus timing.
module tb_z80_cycle_gen;

  localparam int IO_WAITS = 1;

  typedef logic [38:0] bus_t;

  typedef struct {
    bit          io;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          waits;
    logic [7:0]  rdval;
    int          exp_len;
    logic [7:0]  exp_rdata;
  } vec_t;

  logic        clk28 = 1'b0;
  logic        rst, tick, req, req_io, req_wr, wait_n;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, d_in;
  logic [15:0] a;
  logic [7:0]  d_out, rdata;
  logic        d_oe, mreq_n, iorq_n, rd_n, wr_n, busy, done;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  exp_rdata;
  logic [15:0] last_addr;
  logic [7:0]  last_dout;
  bit          last_show;
  vec_t        tbl[8];

  z80_cycle_gen #(.IO_WAITS(IO_WAITS)) dut (
    .clk28(clk28), .rst(rst), .tick(tick), .req(req), .req_io(req_io),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .wait_n(wait_n), .d_in(d_in), .a(a), .d_out(d_out), .d_oe(d_oe),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .busy(busy), .rdata(rdata), .done(done)
  );

  always #5 clk28 = ~clk28;

  function automatic bus_t pack(logic [15:0] av, logic [7:0] dv, logic oe,
                                logic mq, logic iq, logic rn, logic wn,
                                logic bz, logic dn, logic [7:0] rv);
    return {av, dv, oe, mq, iq, rn, wn, bz, dn, rv};
  endfunction

  // Expected bus state in phase p (0 = T1H ... len-1 = T3L) of a cycle.
  function automatic bus_t exp_phase(vec_t v, int p, int len, logic [7:0] rv);
    logic mq, iq, rn, wn, oe;
    mq = 1; iq = 1; rn = 1; wn = 1; oe = 0;
    if (!v.io) begin
      if (p >= 1 && p <= len - 2) begin
        mq = 0;
        if (!v.wr) rn = 0;
      end
      if (v.wr && p >= 3 && p <= len - 2) wn = 0;
    end else if (p >= 2 && p <= len - 2) begin
      iq = 0;
      if (v.wr) wn = 0; else rn = 0;
    end
    if (v.wr && p >= 1) oe = 1;
    return pack(v.addr, v.wr ? v.wdata : 8'h00, oe, mq, iq, rn, wn, 1'b1, 1'b0, rv);
  endfunction

  task automatic check(input string nm, input int p, input bus_t exp, input bit show_dout);
    bus_t act;
    act = pack(a, show_dout ? d_out : 8'h00, d_oe, mreq_n, iorq_n, rd_n, wr_n,
               busy, done, rdata);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s p%0d: bus got %h want %h", nm, p, act, exp);
    end
    vectors++;
    if ((mreq_n === 1'b0 && iorq_n === 1'b0) || (rd_n === 1'b0 && wr_n === 1'b0)) begin
      miscompares++;
      $display("FAIL %s p%0d overlap: mreq_n=%b iorq_n=%b rd_n=%b wr_n=%b want no two low",
               nm, p, mreq_n, iorq_n, rd_n, wr_n);
    end
  endtask

  // Called at a falling edge; one clk28 with tick high, returns at next falling edge.
  task automatic tick_once();
    tick = 1'b1;
    @(negedge clk28);
    tick = 1'b0;
  endtask

  function automatic bus_t idle_exp();
    return pack(last_addr, last_dout, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, exp_rdata);
  endfunction

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      req = 1'b0;
      wait_n = 1'($urandom);
      d_in = 8'($urandom);
      tick_once();
      check("idle", i, idle_exp(), last_show);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk28);
    rst = 1'b0;
    exp_rdata = 8'h00;
    last_addr = 16'h0000;
    last_dout = 8'h00;
    last_show = 1'b1;
  endtask

  // Runs one cycle; seen = ticks after acceptance until done was observed (-1 if never).
  task automatic run_txn(input vec_t v, input string nm, output int seen);
    bit samp[$];
    int forced, len, s;
    bus_t e;
    logic [7:0] rv;
    samp = {};
    forced = v.io ? IO_WAITS : 0;
    samp.push_back(0); samp.push_back(0); samp.push_back(0);
    samp.push_back(forced == 0);
    for (int f = 0; f < forced; f++) begin
      samp.push_back(0);
      samp.push_back(f == forced - 1);
    end
    for (int j = 0; j < v.waits; j++) begin
      samp.push_back(0);
      samp.push_back(1);
    end
    samp.push_back(0); samp.push_back(0);
    len = samp.size();
    seen = -1;
    s = 0;
    req = 1'b1; req_io = v.io; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    wait_n = 1'($urandom); d_in = 8'($urandom);
    tick_once();
    for (int p = 0; p < len; p++) begin
      rv = (p == len - 1 && !v.wr) ? v.rdval : exp_rdata;
      e = exp_phase(v, p, len, rv);
      if (done === 1'b1 && seen < 0) seen = p;
      check(nm, p, e, v.wr);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk28);
        check({nm, "_hold"}, p, e, v.wr);
      end
      // requests and their fields must be ignored while busy
      req = 1'($urandom); req_io = 1'($urandom); req_wr = 1'($urandom);
      req_addr = 16'($urandom); req_wdata = 8'($urandom);
      d_in = (p == len - 2) ? v.rdval : 8'($urandom);
      if (samp[p]) begin
        wait_n = (s < v.waits) ? 1'b0 : 1'b1;
        s++;
      end else begin
        wait_n = 1'($urandom);
      end
      tick_once();
    end
    if (!v.wr) exp_rdata = v.rdval;
    last_addr = v.addr;
    last_dout = v.wr ? v.wdata : 8'h00;
    last_show = v.wr;
    if (done === 1'b1 && seen < 0) seen = len;
    check({nm, "_end"}, len,
          pack(v.addr, last_dout, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, exp_rdata), v.wr);
    @(negedge clk28);
    check({nm, "_post"}, len, idle_exp(), v.wr);
    if (seen < 0) begin
      req = 1'b0;
      for (int k = len + 1; k <= len + 8 && seen < 0; k++) begin
        tick_once();
        if (done === 1'b1) seen = k;
      end
      if (seen < 0) begin
        vectors++;
        miscompares++;
        $display("FAIL %s timeout: done not seen within %0d ticks", nm, len + 8);
        do_reset();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vec_t v;
    bus_t rst_exp;

    tbl[0] = '{0, 0, 16'h4000, 8'h00, 0, 8'hA5, 6,  8'hA5};
    tbl[1] = '{0, 1, 16'h8001, 8'h3C, 0, 8'h11, 6,  8'hA5};
    tbl[2] = '{1, 1, 16'h00FE, 8'h07, 0, 8'h22, 8,  8'hA5};
    tbl[3] = '{0, 0, 16'h1234, 8'h00, 3, 8'h5E, 12, 8'h5E};
    tbl[4] = '{1, 0, 16'h00FE, 8'h00, 2, 8'hC3, 12, 8'hC3};
    tbl[5] = '{0, 1, 16'hFFFF, 8'h81, 1, 8'h33, 8,  8'hC3};
    tbl[6] = '{1, 0, 16'h0000, 8'h00, 0, 8'h00, 8,  8'h00};
    tbl[7] = '{0, 0, 16'h0001, 8'h00, 0, 8'hFF, 6,  8'hFF};

    rst_exp = pack(16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    rst = 1'b1; tick = 1'b0; req = 1'b0; req_io = 1'b0; req_wr = 1'b0;
    req_addr = 16'h0; req_wdata = 8'h0; wait_n = 1'b1; d_in = 8'h0;
    exp_rdata = 8'h00; last_addr = 16'h0; last_dout = 8'h0; last_show = 1'b1;
    repeat (3) @(negedge clk28);
    check("reset", 0, rst_exp, 1'b1);
    rst = 1'b0;
    idle_ticks(2);

    // Directed table, back-to-back with req asserted on the first idle tick.
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], $sformatf("tbl%0d", i), seen);
      vectors++;
      if (seen != tbl[i].exp_len) begin
        miscompares++;
        $display("FAIL tbl%0d length: done after %0d ticks want %0d", i, seen, tbl[i].exp_len);
      end
      vectors++;
      if (rdata !== tbl[i].exp_rdata) begin
        miscompares++;
        $display("FAIL tbl%0d rdata: got %h want %h", i, rdata, tbl[i].exp_rdata);
      end
    end

    // Reset in T2L of a memory write: strobes and d_oe drop without a clock edge.
    v = '{0, 1, 16'h1357, 8'h5A, 0, 8'h00, 6, 8'h00};
    req = 1'b1; req_io = 1'b0; req_wr = 1'b1; req_addr = v.addr; req_wdata = v.wdata;
    tick_once();
    req = 1'b0;
    for (int p = 0; p < 4; p++) begin
      check("rstmid", p, exp_phase(v, p, 6, exp_rdata), 1'b1);
      if (p < 3) tick_once();
    end
    #2 rst = 1'b1;
    #1 check("rstmid_async", 4, rst_exp, 1'b1);
    @(negedge clk28);
    for (int i = 0; i < 3; i++) begin
      tick_once();
      check("rstmid_held", i, rst_exp, 1'b1);
    end
    rst = 1'b0;
    exp_rdata = 8'h00; last_addr = 16'h0; last_dout = 8'h0; last_show = 1'b1;
    idle_ticks(2);
    v = '{0, 0, 16'h2468, 8'h00, 0, 8'h96, 6, 8'h96};
    run_txn(v, "after_rst", seen);
    vectors++;
    if (seen != 6) begin
      miscompares++;
      $display("FAIL after_rst length: done after %0d ticks want 6", seen);
    end

    // Randomized cycles with occasional idle gaps.
    for (int i = 0; i < 40; i++) begin
      v.io = 1'($urandom); v.wr = 1'($urandom);
      v.addr = 16'($urandom); v.wdata = 8'($urandom);
      v.waits = $urandom_range(0, 4); v.rdval = 8'($urandom);
      v.exp_len = 6 + 2 * v.waits + (v.io ? 2 * IO_WAITS : 0);
      v.exp_rdata = 8'h00;
      run_txn(v, $sformatf("rnd%0d", i), seen);
      vectors++;
      if (seen != v.exp_len) begin
        miscompares++;
        $display("FAIL rnd%0d length: done after %0d ticks want %0d", i, seen, v.exp_len);
      end
      if ($urandom_range(0, 3) == 0) idle_ticks($urandom_range(1, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
